// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler (mult_sched) and its arbiter.
// Optional zero-operand bypass in the top is enabled with MULT_SCHED_ZERO_BYPASS_EN.
package mult_sched_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_NREQ = 2;

    // Pointer width for a requester index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr,
// wrapping modulo NREQ, and returns both the one-hot grant and its index.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [PW:0]       sum;

    always_comb begin
        // Rotate so bit 0 of rot is the requester the pointer names.
        dbl     = {req, req} >> ptr;
        rot     = dbl[NREQ-1:0];
        sum     = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && rot[i]) begin
                gnt_any = 1'b1;
                sum     = {1'b0, ptr} + (PW+1)'(i);
            end
        end
        if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
        end
        gnt_idx = sum[PW-1:0];
        gnt     = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative multiplier between NREQ requesters.
// Define MULT_SCHED_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_signed,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [W-1:0]      m_a,
    output logic [W-1:0]      m_b,
    output logic              m_signed,
    output logic              m_doMult,
    input  logic [W-1:0]      m_out,
    input  logic              m_done
);

    localparam int PW = ptr_width(NREQ);

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  prod_q, prod_d;
    logic          sgn_q, sgn_d;
    logic          done_q, done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_sgn;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // One-hot grant makes an OR-mux sufficient for operand selection.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sgn = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a   = sel_a | (arb_gnt[i] ? req_a[i*W +: W] : '0);
            sel_b   = sel_b | (arb_gnt[i] ? req_b[i*W +: W] : '0);
            sel_sgn = sel_sgn | (arb_gnt[i] & req_signed[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        prod_d    = prod_q;
        // Tracking m_done every cycle means a done still high at START is
        // already recorded, so only a fresh rising edge completes WAIT.
        done_d    = m_done;
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        m_a       = '0;
        m_b       = '0;
        m_signed  = 1'b0;
        m_doMult  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by reset so no accept pulse leaks out while reset is held.
                if (arb_any && !reset) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_idx;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    sgn_d     = sel_sgn;
                    state_d   = S_START;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        prod_d  = '0;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_START: begin
                m_doMult = 1'b1;
                m_a      = a_q;
                m_b      = b_q;
                m_signed = sgn_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                m_a      = a_q;
                m_b      = b_q;
                m_signed = sgn_q;
                if (m_done && !done_q) begin
                    prod_d  = m_out;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = NREQ'(1) << gnt_q;
                rsp_data  = prod_q;
                ptr_d     = (gnt_q == PW'(NREQ-1)) ? '0 : gnt_q + PW'(1);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural iterative multiplier whose
// done output stays high after completion until a cycle after the next start.
module tb_mult_sched;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int LAT  = 5;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_signed;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [W-1:0]      m_a;
  logic [W-1:0]      m_b;
  logic              m_signed;
  logic              m_doMult;
  logic [W-1:0]      m_out;
  logic              m_done;

  mult_sched #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_signed   (m_signed),
    .m_doMult   (m_doMult),
    .m_out      (m_out),
    .m_done     (m_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  logic          mdl_busy;
  logic          mdl_done;
  logic [W-1:0]  mdl_out;
  logic [W-1:0]  mdl_a;
  logic [W-1:0]  mdl_b;
  logic          mdl_s;
  int            mdl_cyc;
  logic signed [2*W-1:0] mdl_full;

  assign m_done = mdl_done;
  assign m_out  = mdl_out;

  always_comb begin
    if (mdl_s) mdl_full = $signed({{W{mdl_a[W-1]}}, mdl_a}) * $signed({{W{mdl_b[W-1]}}, mdl_b});
    else       mdl_full = $signed({{W{1'b0}}, mdl_a}) * $signed({{W{1'b0}}, mdl_b});
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_out  <= '0;
      mdl_a    <= '0;
      mdl_b    <= '0;
      mdl_s    <= 1'b0;
      mdl_cyc  <= 0;
    end else if (m_doMult) begin
      mdl_busy <= 1'b1;
      mdl_cyc  <= 0;
      mdl_a    <= m_a;
      mdl_b    <= m_b;
      mdl_s    <= m_signed;
    end else if (mdl_busy) begin
      if (mdl_cyc == 0) mdl_done <= 1'b0;
      if (mdl_cyc == LAT-1) begin
        mdl_done <= 1'b1;
        mdl_out  <= mdl_full[W-1:0];
        mdl_busy <= 1'b0;
      end
      mdl_cyc <= mdl_cyc + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   order_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_domult = 0;
  int   n_ready[NREQ];
  int   exp_ptr = 0;

  initial begin
    for (int i = 0; i < NREQ; i++) n_ready[i] = 0;
  end

  function automatic logic [W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic signed [2*W-1:0] p;
    sa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = sa * sb;
    return p[W-1:0];
  endfunction

  always @(negedge clk) begin
    int rid;
    int found;
    if (!reset) begin
      if (m_doMult) n_domult++;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) n_ready[i]++;
      total++;
      if (((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)) begin
        bad++;
        $display("FAIL ready_legal got=%b valid=%b", req_ready, req_valid);
      end
      if (rsp_valid != '0) begin
        total++;
        if ($countones(rsp_valid) != 1) begin
          bad++;
          $display("FAIL rsp_onehot got=%b want=one-hot", rsp_valid);
        end else begin
          rid = 0;
          for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rid = i;
          found = -1;
          for (int k = 0; k < exp_q.size(); k++) if (found < 0 && exp_q[k].id == rid) found = k;
          if (found < 0) begin
            bad++;
            $display("FAIL rsp_unexpected id=%0d data=%h want=no response", rid, rsp_data);
          end else begin
            total++;
            if (rsp_data !== exp_q[found].data) begin
              bad++;
              $display("FAIL rsp_data id=%0d got=%h want=%h", rid, rsp_data, exp_q[found].data);
            end
            exp_q.delete(found);
          end
          order_q.push_back(rid);
          exp_ptr = (rid + 1) % NREQ;
        end
      end else begin
        total++;
        if (rsp_data !== '0) begin
          bad++;
          $display("FAIL rsp_idle_zero got=%h want=0", rsp_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] exp, input bit push);
    int waited = 0;
    bit acc = 0;
    @(posedge clk); #1;
    req_valid[id]        = 1'b1;
    req_a[id*W +: W]     = a;
    req_b[id*W +: W]     = b;
    req_signed[id]       = s;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = req_ready[id];
      @(posedge clk); #1;
      waited++;
    end
    req_valid[id] = 1'b0;
    if (acc) begin
      if (push) exp_q.push_back('{id: id, data: exp});
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout id=%0d got=no accept want=accept", id);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, m_doMult, m_signed} !== '0) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=0", {req_ready, rsp_valid, m_doMult, m_signed});
    end
    total++;
    if ({rsp_data, m_a, m_b} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", rsp_data, m_a, m_b);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, m_doMult, m_a, m_b} !== '0) begin
      bad++;
      $display("FAIL idle_quiet got=%b/%b/%b want=0", req_ready, rsp_valid, m_doMult);
    end
  endtask

  task automatic test_basic();
    int d0 = n_domult;
    int r0 = n_ready[0];
    issue(0, 32'h3, 32'h17, 1'b0, 32'h45, 1'b1);
    wait_drain(100);
    total++;
    if (n_domult - d0 != 1) begin
      bad++;
      $display("FAIL basic_domult got=%0d want=1", n_domult - d0);
    end
    total++;
    if (n_ready[0] - r0 != 1) begin
      bad++;
      $display("FAIL basic_ready got=%0d want=1", n_ready[0] - r0);
    end
  endtask

  task automatic test_signed();
    bit started = 0;
    bit sig_bad = 0;
    int cyc = 0;
    issue(1, 32'h3, 32'h69, 1'b1, 32'h13B, 1'b1);
    do begin
      @(negedge clk);
      cyc++;
      if (m_doMult) started = 1;
      if (started && !rsp_valid[1] && m_signed !== 1'b1) sig_bad = 1;
    end while (!rsp_valid[1] && cyc < 100);
    total++;
    if (!rsp_valid[1]) begin
      bad++;
      $display("FAIL signed_timeout got=%b want=rsp on 1", rsp_valid);
    end
    total++;
    if (!started || sig_bad) begin
      bad++;
      $display("FAIL signed_hold got=started %0d glitch %0d want=started 1 glitch 0", started, sig_bad);
    end
    wait_drain(100);
  endtask

  task automatic test_wrap();
    issue(0, 32'hFFFF_FFFF, 32'h2, 1'b1, 32'hFFFF_FFFE, 1'b1);
    wait_drain(100);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1);
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    int first = exp_ptr;
    int want;
    order_q.delete();
    fork
      begin
        issue(0, 32'd5, 32'd7, 1'b0, 32'd35, 1'b1);
        issue(0, 32'd11, 32'd13, 1'b0, 32'd143, 1'b1);
      end
      begin
        issue(1, 32'd17, 32'd19, 1'b1, 32'd323, 1'b1);
        issue(1, 32'd23, 32'd29, 1'b1, 32'd667, 1'b1);
      end
    join
    wait_drain(200);
    total++;
    if (order_q.size() != 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=4", order_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        want = (k % 2 == 0) ? first : 1 - first;
        total++;
        if (order_q[k] != want) begin
          bad++;
          $display("FAIL b2b_order slot=%0d got=%0d want=%0d", k, order_q[k], want);
        end
      end
    end
  endtask

  task automatic test_random();
    int id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    for (int n = 0; n < 6; n++) begin
      id = $urandom_range(0, NREQ-1);
      a  = $urandom;
      b  = $urandom;
      s  = 1'($urandom_range(0, 1));
      issue(id, a, b, s, exp_prod(a, b, s), 1'b1);
      wait_drain(100);
    end
  endtask

  task automatic test_reset_midop();
    int c = 0;
    int stray = 0;
    issue(0, 32'd7, 32'd9, 1'b0, 32'd63, 1'b0);
    while (!m_doMult && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (!m_doMult) begin
      bad++;
      $display("FAIL midop_start got=0 want=1");
    end
    repeat (2) @(negedge clk);
    req_valid = '1;
    reset     = 1'b1;
    exp_ptr   = 0;
    #1;
    total++;
    if ({req_ready, rsp_valid, m_doMult, m_signed} !== '0) begin
      bad++;
      $display("FAIL midop_pulses got=%b want=0", {req_ready, rsp_valid, m_doMult, m_signed});
    end
    total++;
    if ({rsp_data, m_a, m_b} !== '0) begin
      bad++;
      $display("FAIL midop_data got=%h/%h/%h want=0", rsp_data, m_a, m_b);
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    reset     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL midop_stray got=%0d want=0", stray);
    end
    issue(1, 32'h1234, 32'h10, 1'b0, 32'h12340, 1'b1);
    wait_drain(100);
  endtask

  task automatic test_zero();
    int d0 = n_domult;
    int lat = 0;
    int want_lat;
    int want_dm;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    want_lat = 1;
    want_dm  = 0;
`else
    // START, six WAIT cycles for this multiplier model, then RESP.
    want_lat = 8;
    want_dm  = 1;
`endif
    issue(0, 32'h0, 32'h1234, 1'b0, 32'h0, 1'b1);
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[0] && lat < 100);
    total++;
    if (lat != want_lat) begin
      bad++;
      $display("FAIL zero_latency got=%0d want=%0d", lat, want_lat);
    end
    wait_drain(100);
    total++;
    if (n_domult - d0 != want_dm) begin
      bad++;
      $display("FAIL zero_domult got=%0d want=%0d", n_domult - d0, want_dm);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_midop();
    test_zero();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
